// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the fetch sequencer and its jump-target LUT.
package fetch_pkg;

    localparam int FETCH_D     = 12;
    localparam int FETCH_LUT_N = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_t;

    typedef enum logic [2:0] {
        NPC_INC,
        NPC_REL,
        NPC_ABS,
        NPC_CALL,
        NPC_RET
    } npc_sel_t;

endpackage

// File: rtl/jump_lut.sv
// Runtime-writable jump-target table: synchronous write and clear, combinational read.
// Indices at or above LUT_N never match an entry, so writes to them are dropped and reads return 0.
module jump_lut
    import fetch_pkg::*;
#(
    parameter int D     = FETCH_D,
    parameter int LUT_N = FETCH_LUT_N,
    parameter int LUT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [LUT_W-1:0] i_wr_idx,
    input  logic [D-1:0]     i_wr_data,
    input  logic [LUT_W-1:0] i_rd_idx,
    output logic [D-1:0]     o_rd_data
);

    logic [D-1:0] r_mem [LUT_N];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LUT_N; i++) begin
            if (reset) begin
                r_mem[i] <= '0;
            end else if (i_wr_en && (i_wr_idx == LUT_W'(i))) begin
                r_mem[i] <= i_wr_data;
            end
        end
    end

    // Read returns the pre-edge contents, so a same-cycle write is not forwarded.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < LUT_N; i++) begin
            if (i_rd_idx == LUT_W'(i)) begin
                o_rd_data = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: program counter, jump-target LUT and req/busy/done handshake.
// Optional return stack enabled by defining FETCH_CALL_STACK_EN.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int D         = FETCH_D,
    parameter int LUT_N     = FETCH_LUT_N,
    parameter int LUT_W     = 2,
    parameter int HALT_ADDR = 128
`ifdef FETCH_CALL_STACK_EN
    ,
    parameter int STACK_DEPTH = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             stall,
    input  logic             absjump_en,
    input  logic             reljump_en,
    input  logic [LUT_W-1:0] lut_sel,
    input  logic [D-1:0]     rel_off,
    input  logic             lut_wr_en,
    input  logic [LUT_W-1:0] lut_wr_idx,
    input  logic [D-1:0]     lut_wr_data,
`ifdef FETCH_CALL_STACK_EN
    input  logic             call_en,
    input  logic             ret_en,
    output logic             stack_err,
`endif
    output logic [D-1:0]     prog_ctr,
    output logic             busy,
    output logic             done
);

    localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_pc_nxt;
    logic [D-1:0] w_pc_sel;
    logic [D-1:0] w_pc_inc;
    logic [D-1:0] w_pc_rel;
    logic [D-1:0] w_lut_data;
    npc_sel_t     w_npc_sel;

    jump_lut #(
        .D     (D),
        .LUT_N (LUT_N),
        .LUT_W (LUT_W)
    ) u_jump_lut (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (lut_wr_en),
        .i_wr_idx  (lut_wr_idx),
        .i_wr_data (lut_wr_data),
        .i_rd_idx  (lut_sel),
        .o_rd_data (w_lut_data)
    );

    assign w_pc_inc = r_pc + D'(1);
    assign w_pc_rel = r_pc + rel_off;

    // Later assignments override earlier ones, giving call > ret > abs > rel > +1.
    always_comb begin
        w_npc_sel = NPC_INC;
        if (absjump_en) begin
            w_npc_sel = NPC_ABS;
        end else if (reljump_en) begin
            w_npc_sel = NPC_REL;
        end
`ifdef FETCH_CALL_STACK_EN
        if (ret_en) begin
            w_npc_sel = NPC_RET;
        end
        if (call_en) begin
            w_npc_sel = NPC_CALL;
        end
`endif
    end

`ifdef FETCH_CALL_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [D-1:0]    r_stack [STACK_DEPTH];
    logic [SP_W-1:0] r_sp;
    logic            r_stack_err;
    logic            w_advance;
    logic            w_push;
    logic            w_pop;
    logic            w_stack_full;
    logic            w_stack_empty;
    logic [D-1:0]    w_ret_addr;

    assign w_advance     = (r_state == RUN) && (r_pc != HALT_PC) && !stall;
    assign w_push        = w_advance && (w_npc_sel == NPC_CALL);
    assign w_pop         = w_advance && (w_npc_sel == NPC_RET);
    assign w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));
    assign w_stack_empty = (r_sp == '0);
    assign stack_err     = r_stack_err;

    always_comb begin
        w_ret_addr = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) begin
                w_ret_addr = r_stack[i];
            end
        end
    end

    // Overflowing calls still jump and underflowing returns fall through to +1; both latch the error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp        <= '0;
            r_stack_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            if ((r_state == IDLE) && req) begin
                r_sp <= '0;
            end else if (w_push && !w_stack_full) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop && !w_stack_empty) begin
                r_sp <= r_sp - SP_W'(1);
            end
            if ((w_push && w_stack_full) || (w_pop && w_stack_empty)) begin
                r_stack_err <= 1'b1;
            end
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (w_push && !w_stack_full && (r_sp == SP_W'(i))) begin
                    r_stack[i] <= w_pc_inc;
                end
            end
        end
    end
`endif

    always_comb begin
        w_pc_sel = w_pc_inc;
        case (w_npc_sel)
            NPC_ABS:  w_pc_sel = w_lut_data;
            NPC_REL:  w_pc_sel = w_pc_rel;
`ifdef FETCH_CALL_STACK_EN
            NPC_CALL: w_pc_sel = w_lut_data;
            NPC_RET:  w_pc_sel = w_stack_empty ? w_pc_inc : w_ret_addr;
`endif
            default:  w_pc_sel = w_pc_inc;
        endcase
    end

    // The halt cycle and stalls both freeze the PC and discard any jump request.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            IDLE: begin
                w_pc_nxt = '0;
                if (req) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_pc == HALT_PC) begin
                    w_state_nxt = DONE;
                end else if (!stall) begin
                    w_pc_nxt = w_pc_sel;
                end
            end
            DONE: begin
                if (!req) begin
                    w_state_nxt = IDLE;
                    w_pc_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign prog_ctr = r_pc;
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: stimulus pushes hand-computed expectations, a monitor pops and compares.
// Define FETCH_CALL_STACK_EN to also exercise the return stack.
module tb_fetch_seq;

    localparam int D = 12;

    logic          clk;
    logic          reset;
    logic          req;
    logic          stall;
    logic          absjump_en;
    logic          reljump_en;
    logic [1:0]    lut_sel;
    logic [D-1:0]  rel_off;
    logic          lut_wr_en;
    logic [1:0]    lut_wr_idx;
    logic [D-1:0]  lut_wr_data;
    logic [D-1:0]  prog_ctr;
    logic          busy;
    logic          done;
`ifdef FETCH_CALL_STACK_EN
    logic          call_en;
    logic          ret_en;
    logic          stack_err;
`endif

    typedef struct {
        logic [D-1:0] pc;
        logic         busy;
        logic         done;
        logic         err;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    exp_t  curExp;
    string curName;
    int    errors = 0;
    int    checks = 0;

    fetch_seq #(
        .D         (D),
        .LUT_N     (4),
        .LUT_W     (2),
        .HALT_ADDR (128)
`ifdef FETCH_CALL_STACK_EN
        ,
        .STACK_DEPTH (2)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .stall       (stall),
        .absjump_en  (absjump_en),
        .reljump_en  (reljump_en),
        .lut_sel     (lut_sel),
        .rel_off     (rel_off),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data),
`ifdef FETCH_CALL_STACK_EN
        .call_en     (call_en),
        .ret_en      (ret_en),
        .stack_err   (stack_err),
`endif
        .prog_ctr    (prog_ctr),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if stimulus stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new PC every cycle, so one expectation is consumed per edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            curExp  = expQ.pop_front();
            curName = nameQ.pop_front();
            checkOutput({curName, ".pc"},   32'(prog_ctr), 32'(curExp.pc));
            checkOutput({curName, ".busy"}, 32'(busy),     32'(curExp.busy));
            checkOutput({curName, ".done"}, 32'(done),     32'(curExp.done));
`ifdef FETCH_CALL_STACK_EN
            checkOutput({curName, ".err"},  32'(stack_err), 32'(curExp.err));
`endif
        end
    end

    task automatic clearInputs();
        req         = 1'b0;
        stall       = 1'b0;
        absjump_en  = 1'b0;
        reljump_en  = 1'b0;
        lut_sel     = '0;
        rel_off     = '0;
        lut_wr_en   = 1'b0;
        lut_wr_idx  = '0;
        lut_wr_data = '0;
`ifdef FETCH_CALL_STACK_EN
        call_en     = 1'b0;
        ret_en      = 1'b0;
`endif
    endtask

    // Inputs are already driven; queue what the outputs must be after the coming edge.
    task automatic applyStimulus(input string name, input logic [D-1:0] pc,
                                 input logic b, input logic d, input logic e = 1'b0);
        exp_t x;
        x.pc   = pc;
        x.busy = b;
        x.done = d;
        x.err  = e;
        expQ.push_back(x);
        nameQ.push_back(name);
        @(negedge clk);
    endtask

    task automatic writeLutIdle(input logic [1:0] idx, input logic [D-1:0] data);
        lut_wr_en   = 1'b1;
        lut_wr_idx  = idx;
        lut_wr_data = data;
        applyStimulus("lutWrIdle", '0, 1'b0, 1'b0);
        lut_wr_en   = 1'b0;
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        @(negedge clk);

        applyStimulus("reset0", '0, 1'b0, 1'b0);
        applyStimulus("reset1", '0, 1'b0, 1'b0);
        reset = 1'b0;

        // Full count to the halt address.
        req = 1'b1;
        applyStimulus("start", '0, 1'b1, 1'b0);
        req = 1'b0;
        for (int i = 1; i <= 128; i++) begin
            applyStimulus("count", D'(i), 1'b1, 1'b0);
        end
        req = 1'b1;
        applyStimulus("halt", 12'd128, 1'b0, 1'b1);
        applyStimulus("holdDone", 12'd128, 1'b0, 1'b1);
        applyStimulus("holdDone", 12'd128, 1'b0, 1'b1);
        req = 1'b0;
        applyStimulus("toIdle", '0, 1'b0, 1'b0);

        absjump_en = 1'b1;
        reljump_en = 1'b1;
        rel_off    = 12'd5;
        applyStimulus("idleIgnore", '0, 1'b0, 1'b0);
        clearInputs();

        writeLutIdle(2'd2, 12'h040);
        writeLutIdle(2'd1, 12'h100);
        writeLutIdle(2'd3, 12'hFF8);

        req = 1'b1;
        applyStimulus("start2", '0, 1'b1, 1'b0);
        req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus("count2", D'(i), 1'b1, 1'b0);
        end

        absjump_en = 1'b1;
        reljump_en = 1'b1;
        lut_sel    = 2'd2;
        rel_off    = 12'd3;
        applyStimulus("absWins", 12'h040, 1'b1, 1'b0);
        clearInputs();
        applyStimulus("inc", 12'h041, 1'b1, 1'b0);
        reljump_en = 1'b1;
        rel_off    = 12'hFFE;
        applyStimulus("relNeg", 12'h03F, 1'b1, 1'b0);
        rel_off    = 12'hFCB;
        applyStimulus("relToTen", 12'd10, 1'b1, 1'b0);
        clearInputs();

        stall      = 1'b1;
        absjump_en = 1'b1;
        lut_sel    = 2'd2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 12'd10, 1'b1, 1'b0);
        end
        clearInputs();
        applyStimulus("resume", 12'd11, 1'b1, 1'b0);

        lut_wr_en   = 1'b1;
        lut_wr_idx  = 2'd1;
        lut_wr_data = 12'h300;
        absjump_en  = 1'b1;
        lut_sel     = 2'd1;
        applyStimulus("wrOld", 12'h100, 1'b1, 1'b0);
        clearInputs();
        absjump_en = 1'b1;
        lut_sel    = 2'd1;
        applyStimulus("wrNew", 12'h300, 1'b1, 1'b0);
        clearInputs();

        lut_wr_en   = 1'b1;
        lut_wr_idx  = 2'd0;
        lut_wr_data = 12'hFFF;
        applyStimulus("incWr", 12'h301, 1'b1, 1'b0);
        clearInputs();
        absjump_en = 1'b1;
        lut_sel    = 2'd0;
        applyStimulus("absTop", 12'hFFF, 1'b1, 1'b0);
        clearInputs();
        applyStimulus("incWrap", 12'h000, 1'b1, 1'b0);
        absjump_en = 1'b1;
        lut_sel    = 2'd3;
        applyStimulus("absHigh", 12'hFF8, 1'b1, 1'b0);
        clearInputs();
        reljump_en = 1'b1;
        rel_off    = 12'h010;
        applyStimulus("relWrap", 12'h008, 1'b1, 1'b0);
        rel_off    = 12'hFFA;
        applyStimulus("relBack", 12'h002, 1'b1, 1'b0);
        rel_off    = 12'hFFC;
        applyStimulus("relNegWrap", 12'hFFE, 1'b1, 1'b0);
        clearInputs();

        // Reset mid-run must also wipe the LUT.
        reset = 1'b1;
        applyStimulus("resetRun", '0, 1'b0, 1'b0);
        reset = 1'b0;
        req = 1'b1;
        applyStimulus("start3", '0, 1'b1, 1'b0);
        clearInputs();
        absjump_en = 1'b1;
        lut_sel    = 2'd2;
        applyStimulus("lutCleared2", '0, 1'b1, 1'b0);
        lut_sel    = 2'd3;
        applyStimulus("lutCleared3", '0, 1'b1, 1'b0);
        clearInputs();
        applyStimulus("inc3", 12'd1, 1'b1, 1'b0);

        lut_wr_en   = 1'b1;
        lut_wr_idx  = 2'd1;
        lut_wr_data = 12'h080;
        applyStimulus("incWr2", 12'd2, 1'b1, 1'b0);
        clearInputs();
        absjump_en = 1'b1;
        lut_sel    = 2'd1;
        applyStimulus("absHalt", 12'h080, 1'b1, 1'b0);
        lut_sel    = 2'd2;
        reljump_en = 1'b1;
        rel_off    = 12'd5;
        applyStimulus("haltIgnores", 12'h080, 1'b0, 1'b1);
        clearInputs();
        applyStimulus("toIdle2", '0, 1'b0, 1'b0);

`ifdef FETCH_CALL_STACK_EN
        reset = 1'b1;
        applyStimulus("rstStack", '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        writeLutIdle(2'd0, 12'h010);
        writeLutIdle(2'd1, 12'h020);
        writeLutIdle(2'd2, 12'h030);
        req = 1'b1;
        applyStimulus("start4", '0, 1'b1, 1'b0, 1'b0);
        clearInputs();
        applyStimulus("inc4", 12'd1, 1'b1, 1'b0, 1'b0);
        call_en    = 1'b1;
        absjump_en = 1'b1;
        lut_sel    = 2'd0;
        applyStimulus("call1", 12'h010, 1'b1, 1'b0, 1'b0);
        lut_sel    = 2'd1;
        applyStimulus("call2", 12'h020, 1'b1, 1'b0, 1'b0);
        lut_sel    = 2'd2;
        applyStimulus("call3Ovf", 12'h030, 1'b1, 1'b0, 1'b1);
        clearInputs();
        ret_en = 1'b1;
        applyStimulus("ret1", 12'h011, 1'b1, 1'b0, 1'b1);
        applyStimulus("ret2", 12'h002, 1'b1, 1'b0, 1'b1);
        applyStimulus("ret3Empty", 12'h003, 1'b1, 1'b0, 1'b1);
        clearInputs();
        reset = 1'b1;
        applyStimulus("rstErr", '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
`endif

        @(negedge clk);
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
